// File: rtl/wvb_reader_arb_pkg.sv
// Shared constants for the waveform-buffer reader arbiter.
//   - FSM state encodings
//   - default channel count and fixed port widths
//   - read-controller response payload
package wvb_reader_arb_pkg;

   localparam int unsigned WVB_N_CHAN_DFLT = 8;
   localparam int unsigned WVB_IDX_W       = 8;
   localparam int unsigned WVB_LEN_W       = 16;
   localparam int unsigned WVB_CNT_W       = 16;

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_SCAN      = 2'd1;
   localparam logic [1:0] S_REQ       = 2'd2;
   localparam logic [1:0] S_HOST_WAIT = 2'd3;

   // Completion info returned by the format read controller alongside rd_ack.
   typedef struct packed {
      logic                 more;
      logic [WVB_LEN_W-1:0] len;
   } rd_rsp_t;

endpackage

// File: rtl/wvb_reader_arb_rr_sel.sv
// Combinational round-robin picker.
//   mask     : per-channel request flags
//   last_idx : channel served most recently; search starts one above it
//   valid    : any mask bit set
//   idx      : chosen channel number
//   onehot   : chosen channel as a one-hot vector (0 when !valid)
module wvb_rr_sel #(
   parameter int unsigned P_N_CHAN = 8,
   parameter int unsigned P_SEL_W  = 3
) (
   input  logic [P_N_CHAN-1:0] mask,
   input  logic [P_SEL_W-1:0]  last_idx,
   output logic                valid,
   output logic [P_SEL_W-1:0]  idx,
   output logic [P_N_CHAN-1:0] onehot
);

   int unsigned        cand;
   logic [P_SEL_W-1:0] cand_idx;

   // Walk (last_idx+1 .. last_idx+P_N_CHAN) mod P_N_CHAN; first hit wins.
   always_comb begin
      valid    = 1'b0;
      idx      = '0;
      onehot   = '0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned k = 1; k <= P_N_CHAN; k++) begin
         cand     = (32'(last_idx) + k) % P_N_CHAN;
         cand_idx = P_SEL_W'(cand);
         if (!valid && mask[cand_idx]) begin
            valid = 1'b1;
            idx   = cand_idx;
         end
      end
      if (valid) onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/wvb_reader_arb.sv
// Arbitrates waveform-buffer channels into the format read controller and
// hands each filled DPRAM to the host.
//   clk, rst             : clock, async active-high reset
//   en, dpram_mode_in    : scan enable, DPRAM mode sampled at selection
//   wvb_not_empty        : per-channel event-available flags
//   rd_req/rd_ack        : request handshake with the read controller
//   rd_more, rd_len      : continuation flag and fill length, valid with rd_ack
//   rd_idx, rd_dpram_mode, wvb_sel : selected channel, held for the whole event
//   dpram_ready/len/done : host handoff of a filled DPRAM
//   evt_cnt              : completed-event counter (wraps)
module wvb_reader_arb
   import wvb_reader_arb_pkg::*;
#(
   parameter int unsigned P_N_CHAN = WVB_N_CHAN_DFLT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 dpram_mode_in,
   input  logic [P_N_CHAN-1:0]  wvb_not_empty,
   input  logic                 rd_ack,
   input  logic                 rd_more,
   input  logic [WVB_LEN_W-1:0] rd_len,
   output logic                 rd_req,
   output logic [WVB_IDX_W-1:0] rd_idx,
   output logic                 rd_dpram_mode,
   output logic [P_N_CHAN-1:0]  wvb_sel,
   output logic                 dpram_ready,
   output logic [WVB_LEN_W-1:0] dpram_len,
   input  logic                 dpram_done,
   output logic [WVB_CNT_W-1:0] evt_cnt
);

   localparam int unsigned SEL_W = (P_N_CHAN > 1) ? $clog2(P_N_CHAN) : 1;

   logic [1:0]           state_q, state_d;
   logic                 rd_req_q, rd_req_d;
   logic [WVB_IDX_W-1:0] rd_idx_q, rd_idx_d;
   logic                 rd_dpram_mode_q, rd_dpram_mode_d;
   logic [P_N_CHAN-1:0]  wvb_sel_q, wvb_sel_d;
   logic                 dpram_ready_q, dpram_ready_d;
   logic [WVB_LEN_W-1:0] dpram_len_q, dpram_len_d;
   logic [WVB_CNT_W-1:0] evt_cnt_q, evt_cnt_d;
   logic                 more_q, more_d;
   logic [SEL_W-1:0]     last_idx_q, last_idx_d;

   logic                 sel_valid;
   logic [SEL_W-1:0]     sel_idx;
   logic [P_N_CHAN-1:0]  sel_onehot;
   rd_rsp_t              rd_rsp;

   assign rd_rsp = '{more: rd_more, len: rd_len};

   wvb_rr_sel #(
      .P_N_CHAN (P_N_CHAN),
      .P_SEL_W  (SEL_W)
   ) u_rr_sel (
      .mask     (wvb_not_empty),
      .last_idx (last_idx_q),
      .valid    (sel_valid),
      .idx      (sel_idx),
      .onehot   (sel_onehot)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d         = state_q;
      rd_req_d        = rd_req_q;
      rd_idx_d        = rd_idx_q;
      rd_dpram_mode_d = rd_dpram_mode_q;
      wvb_sel_d       = wvb_sel_q;
      dpram_ready_d   = dpram_ready_q;
      dpram_len_d     = dpram_len_q;
      evt_cnt_d       = evt_cnt_q;
      more_d          = more_q;
      last_idx_d      = last_idx_q;

      case (state_q)
         S_IDLE: begin
            if (en) state_d = S_SCAN;
         end
         S_SCAN: begin
            if (sel_valid) begin
               state_d         = S_REQ;
               rd_req_d        = 1'b1;
               rd_idx_d        = WVB_IDX_W'(sel_idx);
               wvb_sel_d       = sel_onehot;
               rd_dpram_mode_d = dpram_mode_in;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            if (rd_ack) begin
               state_d       = S_HOST_WAIT;
               rd_req_d      = 1'b0;
               dpram_ready_d = 1'b1;
               dpram_len_d   = rd_rsp.len;
               more_d        = rd_rsp.more;
            end
         end
         S_HOST_WAIT: begin
            if (dpram_done) begin
               dpram_ready_d = 1'b0;
               dpram_len_d   = '0;
               if (more_q) begin
                  // Continuation keeps the channel selection untouched.
                  state_d  = S_REQ;
                  rd_req_d = 1'b1;
               end else begin
                  evt_cnt_d  = evt_cnt_q + WVB_CNT_W'(1);
                  last_idx_d = SEL_W'(rd_idx_q);
                  wvb_sel_d  = '0;
                  state_d    = en ? S_SCAN : S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= S_IDLE;
         rd_req_q        <= 1'b0;
         rd_idx_q        <= '0;
         rd_dpram_mode_q <= 1'b0;
         wvb_sel_q       <= '0;
         dpram_ready_q   <= 1'b0;
         dpram_len_q     <= '0;
         evt_cnt_q       <= '0;
         more_q          <= 1'b0;
         last_idx_q      <= SEL_W'(P_N_CHAN - 1);
      end else begin
         state_q         <= state_d;
         rd_req_q        <= rd_req_d;
         rd_idx_q        <= rd_idx_d;
         rd_dpram_mode_q <= rd_dpram_mode_d;
         wvb_sel_q       <= wvb_sel_d;
         dpram_ready_q   <= dpram_ready_d;
         dpram_len_q     <= dpram_len_d;
         evt_cnt_q       <= evt_cnt_d;
         more_q          <= more_d;
         last_idx_q      <= last_idx_d;
      end
   end

   assign rd_req        = rd_req_q;
   assign rd_idx        = rd_idx_q;
   assign rd_dpram_mode = rd_dpram_mode_q;
   assign wvb_sel       = wvb_sel_q;
   assign dpram_ready   = dpram_ready_q;
   assign dpram_len     = dpram_len_q;
   assign evt_cnt       = evt_cnt_q;

endmodule
